// File: rtl/zorro_pkg.sv
// Shared types and defaults for the Zorro III bus-mastership requester.
// Holds the requester state encoding and channel-selection helpers.
package zorro_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_OWN,
    S_DRAIN,
    S_BACKOFF
  } state_t;

  localparam int DEF_CNT_W         = 8;
  localparam int DEF_TENURE_MAX    = 64;
  localparam int DEF_GRANT_TIMEOUT = 255;
  localparam int DEF_HOLDOFF       = 2;

  // Single requester wins outright; with both requesting the pointer decides.
  function automatic logic pick_ch(input logic [1:0] req, input logic ptr);
    return (req == 2'b11) ? ptr : req[1];
  endfunction

  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/zorro_sync2.sv
// Two-flop synchronizer for active-low asynchronous bus strobes; 2-clock latency,
// resets to 1 so a strobe reads as deasserted until real samples arrive.
module zorro_sync2 (
  input  logic CLK,
  input  logic RESET_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zorro_bus_requester.sv
// Zorro III bus-mastership requester: round-robin between two DMA channels, SBR_n/SBG_n
// handshake with tenure limit and grant timeout; grant-to-MASTER is 3 clocks, REQ is level-held.
module zorro_bus_requester
  import zorro_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TENURE_MAX    = DEF_TENURE_MAX,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int HOLDOFF       = DEF_HOLDOFF
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       RST,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  input  logic       CYC_ACTIVE,
  input  logic       SBG_n,
  output logic       SBR_n,
  output logic       MASTER,
  output logic       TMO
);

  localparam logic [CNT_W-1:0] TEN_LIM   = CNT_W'(TENURE_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

  state_t           state, state_nxt;
  logic             sel, sel_nxt;
  logic             ptr, ptr_nxt;
  logic             abort, abort_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic [CNT_W-1:0] ten_cnt, ten_nxt, ten_inc;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             sbr_nxt, master_nxt, tmo_nxt;
  logic [1:0]       gnt_nxt;
  logic             sbg_sync, sg;

  zorro_sync2 u_sbg_sync (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .d       (SBG_n),
    .q       (sbg_sync)
  );

  assign sg      = ~sbg_sync;
  assign ten_inc = (ten_cnt == TEN_LIM) ? ten_cnt : ten_cnt + 1'b1;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= S_IDLE;
      sel      <= 1'b0;
      ptr      <= 1'b0;
      abort    <= 1'b0;
      wait_cnt <= '0;
      ten_cnt  <= '0;
      hold_cnt <= '0;
      SBR_n    <= 1'b1;
      MASTER   <= 1'b0;
      GNT      <= 2'b00;
      TMO      <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      abort    <= abort_nxt;
      wait_cnt <= wait_nxt;
      ten_cnt  <= ten_nxt;
      hold_cnt <= hold_nxt;
      SBR_n    <= sbr_nxt;
      MASTER   <= master_nxt;
      GNT      <= gnt_nxt;
      TMO      <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    ptr_nxt    = ptr;
    abort_nxt  = abort;
    wait_nxt   = wait_cnt;
    ten_nxt    = ten_cnt;
    hold_nxt   = hold_cnt;
    sbr_nxt    = SBR_n;
    master_nxt = MASTER;
    gnt_nxt    = GNT;
    tmo_nxt    = TMO;

    case (state)
      S_IDLE: begin
        sbr_nxt = 1'b1;
        if (REQ != 2'b00 && !RST) begin
          sel_nxt   = pick_ch(REQ, ptr);
          wait_nxt  = '0;
          sbr_nxt   = 1'b0;
          state_nxt = S_ARB;
        end
      end

      S_ARB: begin
        // An abandoned request beats a simultaneous grant: never hand the bus to an idle channel.
        if (RST || !REQ[sel]) begin
          sbr_nxt   = 1'b1;
          wait_nxt  = '0;
          state_nxt = S_IDLE;
        end else if (sg && !CYC_ACTIVE) begin
          sbr_nxt    = 1'b1;
          master_nxt = 1'b1;
          gnt_nxt    = ch_onehot(sel);
          tmo_nxt    = 1'b0;
          ten_nxt    = '0;
          wait_nxt   = '0;
          state_nxt  = S_OWN;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo_nxt   = 1'b1;
          sbr_nxt   = 1'b1;
          wait_nxt  = '0;
          hold_nxt  = '0;
          state_nxt = S_BACKOFF;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end

      S_OWN: begin
        sbr_nxt = 1'b1;
        ten_nxt = ten_inc;
        if (RST) begin
          gnt_nxt   = 2'b00;
          abort_nxt = 1'b1;
          state_nxt = S_DRAIN;
        end else if (!REQ[sel] || ten_inc == TEN_LIM || !sg) begin
          gnt_nxt   = 2'b00;
          state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        sbr_nxt = 1'b1;
        gnt_nxt = 2'b00;
        if (!CYC_ACTIVE) begin
          master_nxt = 1'b0;
          // A bus-reset abort is not a completed tenure, so the pointer stays put.
          if (abort || RST) begin
            abort_nxt = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            ptr_nxt   = ~sel;
            hold_nxt  = '0;
            state_nxt = S_BACKOFF;
          end
        end
      end

      S_BACKOFF: begin
        sbr_nxt = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      default: begin
        sbr_nxt    = 1'b1;
        master_nxt = 1'b0;
        gnt_nxt    = 2'b00;
        state_nxt  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_zorro_bus_requester.sv
// Directed bench for zorro_bus_requester: grant handshake, round-robin tenures,
// timeout/backoff, drain, bus reset and asynchronous reset, with a grant scoreboard.
module tb_zorro_bus_requester;

  localparam int HOLDOFF = 2;

  logic       CLK = 1'b0;
  logic       RESET_n;
  logic       RST;
  logic [1:0] REQ;
  logic [1:0] GNT;
  logic       CYC_ACTIVE;
  logic       SBG_n;
  logic       SBR_n;
  logic       MASTER;
  logic       TMO;

  typedef struct {
    logic [1:0] gnt;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   grants_seen = 0;
  logic inv_bad     = 1'b0;

  always #5 CLK = ~CLK;

  zorro_bus_requester #(
    .CNT_W         (8),
    .TENURE_MAX    (64),
    .GRANT_TIMEOUT (255),
    .HOLDOFF       (HOLDOFF)
  ) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .RST        (RST),
    .REQ        (REQ),
    .GNT        (GNT),
    .CYC_ACTIVE (CYC_ACTIVE),
    .SBG_n      (SBG_n),
    .SBR_n      (SBR_n),
    .MASTER     (MASTER),
    .TMO        (TMO)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [1:0] g, input int len);
    exp_t e;
    e.gnt = g;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_master(input logic v, input int bound, input string tag);
    int n;
    n = 0;
    while (MASTER !== v && n < bound) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, int'(MASTER === v), 1);
  endtask

  task automatic wait_sbr(input logic v, input int bound, input string tag);
    int n;
    n = 0;
    while (SBR_n !== v && n < bound) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, int'(SBR_n === v), 1);
  endtask

  // Grant monitor: each GNT pulse is matched against the next expected grant.
  logic       in_pulse = 1'b0;
  logic [1:0] pulse_gnt;
  int         plen;
  exp_t       got_e;

  always @(negedge CLK) begin
    if (GNT === 2'b11 || (GNT !== 2'b00 && MASTER !== 1'b1)) inv_bad = 1'b1;
    if (GNT !== 2'b00) begin
      if (!in_pulse) begin
        in_pulse  = 1'b1;
        pulse_gnt = GNT;
        plen      = 0;
      end
      plen++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      grants_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 1, 0);
      end else begin
        got_e = exp_q.pop_front();
        chk("grant_ch", int'(pulse_gnt), int'(got_e.gnt));
        if (got_e.len != 0) chk("grant_len", plen, got_e.len);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   base;
    int   gap;
    int   cnt;
    logic prev_m;
    logic counting;
    logic m_held;
    logic low_seen;

    RESET_n    = 1'b0;
    RST        = 1'b0;
    REQ        = 2'b00;
    CYC_ACTIVE = 1'b0;
    SBG_n      = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_sbr", int'(SBR_n), 1);
    chk("rst_master", int'(MASTER), 0);
    chk("rst_gnt", int'(GNT), 0);
    chk("rst_tmo", int'(TMO), 0);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Single ch0 request, grant arrives 5 clocks after SBR_n falls.
    REQ = 2'b01;
    wait_sbr(1'b0, 10, "s1_sbr_fall");
    repeat (5) @(negedge CLK);
    SBG_n = 1'b0;
    push_exp(2'b01, 10);
    repeat (2) @(negedge CLK);
    chk("s1_master_early", int'(MASTER), 0);
    @(negedge CLK);
    chk("s1_master_3clk", int'(MASTER), 1);
    chk("s1_gnt", int'(GNT), 1);
    chk("s1_sbr_release", int'(SBR_n), 1);
    chk("s1_tmo", int'(TMO), 0);
    repeat (9) @(negedge CLK);
    REQ   = 2'b00;
    SBG_n = 1'b1;
    @(negedge CLK);
    chk("s1_gnt_drop", int'(GNT), 0);
    chk("s1_master_drain", int'(MASTER), 1);
    @(negedge CLK);
    chk("s1_master_off", int'(MASTER), 0);
    repeat (5) @(negedge CLK);

    // Both channels requesting, grant held: pointer is now ch1 after ch0's tenure.
    base  = grants_seen;
    REQ   = 2'b11;
    SBG_n = 1'b0;
    push_exp(2'b10, 64);
    push_exp(2'b01, 64);
    push_exp(2'b10, 64);
    prev_m   = MASTER;
    counting = 1'b0;
    gap      = 0;
    for (int i = 0; i < 600 && grants_seen < base + 3; i++) begin
      @(negedge CLK);
      if (counting) begin
        if (SBR_n) begin
          gap++;
        end else begin
          chk("s2_holdoff_min", int'(gap >= HOLDOFF), 1);
          chk("s2_holdoff_max", int'(gap <= HOLDOFF + 1), 1);
          counting = 1'b0;
        end
      end
      if (prev_m && !MASTER) begin
        counting = 1'b1;
        gap      = 1;
      end
      prev_m = MASTER;
    end
    chk("s2_three_tenures", int'(grants_seen >= base + 3), 1);
    REQ   = 2'b00;
    SBG_n = 1'b1;
    repeat (8) @(negedge CLK);

    // Grant never comes: timeout, backoff, then re-request.
    REQ = 2'b01;
    wait_sbr(1'b0, 10, "s3_sbr_fall");
    cnt = 0;
    while (SBR_n === 1'b0 && cnt < 400) begin
      cnt++;
      @(negedge CLK);
    end
    chk("s3_sbr_low_len", cnt, 255);
    chk("s3_tmo_set", int'(TMO), 1);
    cnt = 0;
    while (SBR_n === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge CLK);
    end
    chk("s3_backoff_min", int'(cnt >= HOLDOFF), 1);
    chk("s3_backoff_max", int'(cnt <= HOLDOFF + 1), 1);
    chk("s3_tmo_sticky", int'(TMO), 1);
    SBG_n = 1'b0;
    push_exp(2'b01, 4);
    repeat (3) @(negedge CLK);
    chk("s3_master_regrant", int'(MASTER), 1);
    chk("s3_tmo_cleared", int'(TMO), 0);

    // Request drops with a cycle still in flight: MASTER waits for it.
    repeat (3) @(negedge CLK);
    REQ        = 2'b00;
    CYC_ACTIVE = 1'b1;
    @(negedge CLK);
    chk("s4_gnt_drop", int'(GNT), 0);
    m_held = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge CLK);
      m_held = m_held & MASTER;
    end
    chk("s4_master_held", int'(m_held), 1);
    CYC_ACTIVE = 1'b0;
    @(negedge CLK);
    chk("s4_master_off", int'(MASTER), 0);
    repeat (5) @(negedge CLK);

    // Pointer flipped to ch1; bus reset mid-tenure must not move it.
    REQ = 2'b11;
    push_exp(2'b10, 3);
    wait_master(1'b1, 10, "s5_own");
    chk("s5_ptr_ch1", int'(GNT), 2);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("s5_rst_gnt", int'(GNT), 0);
    @(negedge CLK);
    chk("s5_rst_master", int'(MASTER), 0);
    chk("s5_rst_gnt2", int'(GNT), 0);
    low_seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (SBR_n !== 1'b1) low_seen = 1'b1;
    end
    chk("s5_no_req_in_rst", int'(low_seen), 0);
    RST = 1'b0;
    push_exp(2'b10, 3);
    wait_master(1'b1, 10, "s5_rearb");
    chk("s5_ptr_kept", int'(GNT), 2);

    // Asynchronous reset in the middle of a tenure.
    repeat (2) @(negedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("s6_async_sbr", int'(SBR_n), 1);
    chk("s6_async_master", int'(MASTER), 0);
    chk("s6_async_gnt", int'(GNT), 0);
    REQ = 2'b10;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    push_exp(2'b10, 1);
    wait_master(1'b1, 10, "s6_own");
    chk("s6_ch1_first", int'(GNT), 2);
    REQ = 2'b00;
    repeat (4) @(negedge CLK);

    chk("all_grants_seen", exp_q.size(), 0);
    chk("grant_invariants", int'(inv_bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zorro_bus_requester.md
Name: zorro_bus_requester

Overview:
- Local-side bus-mastership controller for the Zorro III card.
- Arbitrates between two on-card DMA requesters (ch0 = SCSI DMA, ch1 = aux/buffer DMA) with round-robin priority.
- Requests the Zorro bus via SBR_n and waits for SBG_n, then holds ownership under a tenure limit and releases cleanly after the last cycle completes.
- Sits between the DMA engines and the card's master-arbiter logic; its MASTER output feeds that arbiter.

Parameters:
- CNT_W, 8, width of the tenure and grant-timeout counters.
- TENURE_MAX, 64, maximum clocks of ownership per tenure; must be less than 2^CNT_W.
- GRANT_TIMEOUT, 255, clocks to wait for SBG_n before backing off; must be less than 2^CNT_W.
- HOLDOFF, 2, idle clocks after release before re-requesting; must be at least 1.

Ports:
- CLK  in  1  system clock; single clock domain.
- RESET_n  in  1  asynchronous active-low reset.
- RST  in  1  Zorro bus reset, synchronous level; forces release.
- REQ  in  2  per-channel bus request, level; bit0 = ch0, bit1 = ch1.
- GNT  out  2  one-hot grant to the owning channel.
- CYC_ACTIVE  in  1  a master cycle is in flight (FCS asserted or DTACK pending).
- SBG_n  in  1  bus grant from the arbiter, asynchronous; synchronized internally.
- SBR_n  out  1  bus request to the arbiter, active low.
- MASTER  out  1  card owns the bus.
- TMO  out  1  sticky flag: a grant timeout occurred; cleared when the next tenure starts.

Behaviour:
- Reset values: SBR_n=1, MASTER=0, GNT=2'b00, TMO=0, round-robin pointer=ch0, state=IDLE.
- SBG_n passes through a 2-flop synchronizer; sg = ~synchronized SBG_n. Grant-to-MASTER latency is therefore 3 clocks (2 sync + 1 registered).
- States:
  - IDLE: SBR_n=1. If REQ≠0 and RST=0, latch the selected channel (below) and go to ARB.
  - ARB: SBR_n=0; the wait counter increments each clock.
    - sg=1 and CYC_ACTIVE=0: go to OWN. Set MASTER=1, GNT=onehot(sel), TMO=0, clear the tenure counter.
    - Wait counter reaches GRANT_TIMEOUT: set TMO=1, SBR_n=1, go to BACKOFF.
    - REQ[sel] drops before grant: SBR_n=1, go to IDLE. No grant is issued.
  - OWN: SBR_n=1, MASTER=1. The tenure counter increments each clock, saturating at TENURE_MAX.
    - Leave when REQ[sel]=0, or counter=TENURE_MAX, or sg=0 (arbiter revoke): drop GNT next clock, go to DRAIN.
  - DRAIN: GNT=0, MASTER=1 until CYC_ACTIVE=0. Then MASTER=0, flip the pointer to ~sel, go to BACKOFF.
  - BACKOFF: count HOLDOFF clocks with SBR_n=1, then go to IDLE.
- Selection:
  - Only ch0 requesting → ch0. Only ch1 requesting → ch1.
  - Both requesting → the channel named by the pointer. The pointer flips only after a completed tenure, not after a timeout or abandon.
- GNT is never asserted outside OWN. At most one GNT bit is set. GNT=0 whenever MASTER=0.
- A channel whose tenure hit TENURE_MAX with REQ still high re-arbitrates from IDLE. If the other channel is requesting, it wins.
- RST=1 in any state:
  - Next clock: SBR_n=1, GNT=0.
  - From OWN or DRAIN: MASTER stays 1 only until CYC_ACTIVE=0, then state goes to IDLE. The pointer is not updated.
  - No new request is made while RST=1.
- RESET_n low mid-tenure forces all outputs to reset values immediately, asynchronously.
- Counters never wrap: the tenure counter saturates and the wait counter clears on leaving ARB.

Decomposition:
- Shared package zorro_pkg:
  - state enum (IDLE, ARB, OWN, DRAIN, BACKOFF);
  - default TENURE_MAX, GRANT_TIMEOUT and HOLDOFF constants.
- One sub-module: zorro_sync2, a 2-flop synchronizer with reset value 1 for active-low inputs. Reused for SBG_n and later for other asynchronous bus strobes.

Test Plan:
- REQ=01, SBG_n asserted 5 clocks after SBR_n falls, CYC_ACTIVE=0 → MASTER=1 and GNT=01 exactly 3 clocks after SBG_n. SBR_n=1 in the same clock MASTER rises.
- REQ=11 held, SBG_n always low, TENURE_MAX=64 → tenures alternate ch0, ch1, ch0, …, each GNT pulse 64 clocks. At least HOLDOFF=2 idle clocks between MASTER deassert and the next SBR_n assert.
- REQ=01, SBG_n never asserted → SBR_n low for 255 clocks, then TMO=1, SBR_n=1 for 2 clocks, then re-request. TMO clears on the next successful grant.
- In OWN, REQ[0] drops while CYC_ACTIVE=1 for 4 more clocks → GNT=00 next clock, MASTER held 4 clocks then falls, pointer flips to ch1.
- RST pulsed mid-OWN with CYC_ACTIVE=0 → GNT=00 and MASTER=0 within 2 clocks, state IDLE, pointer unchanged. No SBR_n while RST=1.
- RESET_n low during OWN → SBR_n=1, MASTER=0, GNT=00 asynchronously. After release with REQ=10, ch1 is served first.
